// File: rtl/ram_slot_arbiter.sv
// ram_slot_arbiter
// Shares one 64 KB SRAM between ULA video fetch, the CPU and a DMA loader.
// Every phi2 half-cycle is one SRAM slot: phi2 low belongs to video, phi2 high
// to the CPU, and CPU slots the CPU does not use are handed to DMA.
// Build option: define ARB_DMA_VIDEO_STEAL_EN to let a pending DMA request take
// a video slot, never two consecutive video slots in a row.
module ram_slot_arbiter #(
  parameter int SETUP  = 1,
  parameter int WE_LEN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phi2,
  input  logic [15:0] vidA,
  output logic [7:0]  vidQ,
  input  logic        cpuSel,
  input  logic        cpuWr,
  input  logic [15:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic [7:0]  cpuQ,
  input  logic        dmaReq,
  input  logic        dmaWr,
  input  logic [15:0] dmaA,
  input  logic [7:0]  dmaD,
  output logic [7:0]  dmaQ,
  output logic        dmaAck,
  output logic [15:0] ramA,
  output logic [7:0]  ramD,
  output logic        ramWe,
  input  logic [7:0]  ramQ,
  output logic [1:0]  grant,
  output logic        ovr
);

  localparam logic [1:0] OWN_VID  = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] WE_LAST    = 8'(WE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        phi2_q;
  logic        slot_edge;
  logic        last_acc;
  logic        wr_q;

  logic [1:0]  own_n;
  logic [15:0] addr_n;
  logic [7:0]  data_n;
  logic        wr_n;

`ifdef ARB_DMA_VIDEO_STEAL_EN
  logic        steal_q, steal_n;
`endif

  // Any level change on phi2 opens a new slot (cycle 0 of that slot).
  assign slot_edge = (phi2 != phi2_q);

  // Pick the owner of the slot starting now and the access it will perform.
  always_comb begin
    own_n  = OWN_NONE;
    addr_n = ramA;
    data_n = ramD;
    wr_n   = 1'b0;
`ifdef ARB_DMA_VIDEO_STEAL_EN
    steal_n = steal_q;
`endif
    if (!phi2) begin
`ifdef ARB_DMA_VIDEO_STEAL_EN
      if (dmaReq && !steal_q) begin
        own_n   = OWN_DMA;
        addr_n  = dmaA;
        data_n  = dmaD;
        wr_n    = dmaWr;
        steal_n = 1'b1;
      end else begin
        own_n   = OWN_VID;
        addr_n  = vidA;
        steal_n = 1'b0;
      end
`else
      own_n  = OWN_VID;
      addr_n = vidA;
`endif
    end else if (cpuSel) begin
      own_n  = OWN_CPU;
      addr_n = cpuA;
      data_n = cpuD;
      wr_n   = cpuWr;
    end else if (dmaReq) begin
      own_n  = OWN_DMA;
      addr_n = dmaA;
      data_n = dmaD;
      wr_n   = dmaWr;
    end
  end

  // Slot sequencer next state: a slot edge always restarts the sequence.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_acc = 1'b0;
    if (slot_edge) begin
      state_n = (own_n == OWN_NONE) ? S_IDLE : S_SETUP;
      cnt_n   = '0;
    end else begin
      case (state)
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state_n = S_ACCESS;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        S_ACCESS: begin
          if (cnt == WE_LAST) begin
            state_n  = S_DONE;
            cnt_n    = '0;
            last_acc = 1'b1;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef ARB_DMA_VIDEO_STEAL_EN
  // Steal flag remembers that the previous video slot went to DMA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      steal_q <= 1'b0;
    end else if (slot_edge) begin
      steal_q <= steal_n;
    end
  end
`endif

  // SRAM pins, owner, read-data capture and the overrun flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phi2_q <= 1'b0;
      wr_q   <= 1'b0;
      ramA   <= '0;
      ramD   <= '0;
      ramWe  <= 1'b0;
      vidQ   <= '0;
      cpuQ   <= '0;
      dmaQ   <= '0;
      grant  <= OWN_NONE;
      ovr    <= 1'b0;
    end else begin
      phi2_q <= phi2;
      // Strobe only while in ACCESS; it drops on the same edge that latches
      // a new slot, so address and data never move under an active strobe.
      ramWe  <= (state_n == S_ACCESS) && wr_q;
      if (slot_edge) begin
        grant <= own_n;
        if (state != S_IDLE) begin
          ovr <= 1'b1;
        end
        if (own_n != OWN_NONE) begin
          ramA <= addr_n;
          ramD <= data_n;
          wr_q <= wr_n;
        end
      end
      if (last_acc && !wr_q) begin
        case (grant)
          OWN_VID: vidQ <= ramQ;
          OWN_CPU: cpuQ <= ramQ;
          OWN_DMA: dmaQ <= ramQ;
          default: ;
        endcase
      end
    end
  end

  // Ack is withheld when the slot ends during DONE, so that access is retried.
  assign dmaAck = (state == S_DONE) && (grant == OWN_DMA) && !slot_edge;

endmodule

// File: doc/ram_slot_arbiter.md
# ram_slot_arbiter

Sequences the single 64 KB SRAM between ULA video fetch, CPU and a DMA loader port (tape image/snapshot injection). Each phi2 half-cycle becomes one SRAM slot: phi2 low is the video slot, phi2 high is the CPU slot. Unused CPU slots go to DMA. Sits between ULA/CPU address muxing and the external SRAM pins in the Atmos top level, replacing ad-hoc `ramA`/`ramWe` steering.

## Interface
- `SETUP`, 1: clocks of address setup before write strobe (≥1).
- `WE_LEN`, 2: clocks of write strobe; also read-settle time (≥1).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `phi2`  in  1  ULA phase; any level change starts a new slot.
- `vidA`  in  16  ULA video fetch address.
- `vidQ`  out  8  video read data, captured per video slot.
- `cpuSel`  in  1  CPU slot targets RAM (CSRAMn low).
- `cpuWr`  in  1  CPU write (rw low) with `cpuSel`.
- `cpuA`  in  16  CPU address.
- `cpuD`  in  8  CPU write data.
- `cpuQ`  out  8  CPU read data, captured per granted CPU slot.
- `dmaReq`  in  1  DMA request, level, held until `dmaAck`.
- `dmaWr`  in  1  DMA write (1) / read (0).
- `dmaA`  in  16  DMA address.
- `dmaD`  in  8  DMA write data.
- `dmaQ`  out  8  DMA read data, valid with `dmaAck`.
- `dmaAck`  out  1  one-clock completion pulse.
- `ramA`  out  16  SRAM address.
- `ramD`  out  8  SRAM write data.
- `ramWe`  out  1  SRAM write strobe, active high.
- `ramQ`  in  8  SRAM read data.
- `grant`  out  2  current owner: 0 video, 1 CPU, 2 DMA, 3 none.
- `ovr`  out  1  sticky: a slot ended before its access completed.

## Operation
- Reset values: `ramA`=0, `ramD`=0, `ramWe`=0, `vidQ`=`cpuQ`=`dmaQ`=0, `dmaAck`=0, `grant`=3, `ovr`=0, FSM IDLE.
- `phi2` registered into `phi2_q`; edge = `phi2 != phi2_q`, evaluated in cycle 0 of a slot.
- Owner chosen on edge: phi2 now low → video. Phi2 now high → CPU if `cpuSel`, else DMA if `dmaReq`, else none (3).
- Owner's address/data/direction latched at edge; requester inputs ignored for the remainder of the slot.
- FSM: IDLE → SETUP (`SETUP` clocks) → ACCESS (`WE_LEN` clocks, `ramWe`=1 if write) → DONE (1 clock) → IDLE. Owner 3 stays IDLE.
- Read data sampled from `ramQ` on the last ACCESS clock into `vidQ`/`cpuQ`/`dmaQ` per owner; writes leave Q regs unchanged.
- `dmaAck` pulses in DONE of a DMA slot, read or write. DMA master may change request in the clock after `dmaAck`.
- Edge while not IDLE: access truncated (`ramWe` drops same clock edge as next-slot latch), `ovr` set. Truncated DMA gets no ack and is retried at next eligible slot. New slot starts normally.
- `ovr` cleared only by `reset`.
- `dmaReq` dropped before ack: a latched access still completes and acks; unlatched request simply vanishes.

## Timing
- Slot length must be ≥ `SETUP`+`WE_LEN`+2 clocks; shorter slots produce `ovr`.
- Cycle 0 edge detect/latch; `ramA` valid cycle 1; `ramWe` cycles `SETUP`+1..`SETUP`+`WE_LEN`; Q captured end of cycle `SETUP`+`WE_LEN`; `dmaAck` cycle `SETUP`+`WE_LEN`+1.
- `ramA`/`ramD` held stable from cycle 1 until next slot's cycle 1; never change while `ramWe`=1.
- Async `reset` low: `ramWe` forced 0 immediately, mid-access data lost, no ack.

## Configuration
- `ARB_DMA_VIDEO_STEAL_EN` defined: a video slot with `dmaReq` high goes to DMA, limited to at most one of every two consecutive video slots (steal toggle flag, reset 0); stolen video slot leaves `vidQ` unchanged.
- Undefined: video slots always belong to video; DMA uses only idle CPU slots.

## Test plan
- Slot 8 clocks, `cpuSel`=1 write `cpuA`=$1234 `cpuD`=$5A → `ramA`=$1234 cycle 1, `ramWe` high cycles 2–3, `grant`=1.
- Video slot `vidA`=$BB80, `ramQ`=$41 → `vidQ`=$41 after cycle 3, `ramWe` never high.
- `cpuSel`=0, `dmaReq`=1 read $0500, `ramQ`=$C3 → `grant`=2, `dmaQ`=$C3, one `dmaAck` pulse cycle 4; no DMA in video slot.
- Slot 3 clocks with DMA write → `ovr`=1, no `dmaAck`, retried next CPU slot; `ovr` stays 1.
- `reset` low during `ramWe`=1 → `ramWe`=0 immediately, all outputs at reset values.
- With `ARB_DMA_VIDEO_STEAL_EN`, `dmaReq` held over 4 video slots → DMA gets slots 1 and 3, video gets 2 and 4.
